// File: rtl/av2_coeff_encoder_if.sv
// Stream bundle between the quantizer / coefficient encoder / entropy-encoder symbol input.
// master = producer of coefficients and consumer of symbols; slave = the encoder itself.
interface av2_coeff_encoder_if #(
    parameter int unsigned COEFF_W = 16
) ();
    logic                       start;
    logic [5:0]                 tx_size;
    logic [15:0]                num_coeffs;
    logic signed [COEFF_W-1:0]  coeff_in;
    logic                       coeff_valid;
    logic                       coeff_ready;
    logic [15:0]                symbol;
    logic [15:0]                context_idx;
    logic                       symbol_valid;
    logic                       symbol_ready;
    logic                       busy;
    logic                       done;

    modport master (
        output start, tx_size, num_coeffs, coeff_in, coeff_valid, symbol_ready,
        input  coeff_ready, symbol, context_idx, symbol_valid, busy, done
    );

    modport slave (
        input  start, tx_size, num_coeffs, coeff_in, coeff_valid, symbol_ready,
        output coeff_ready, symbol, context_idx, symbol_valid, busy, done
    );
endinterface

// File: rtl/av2_coeff_encoder.sv
// Buffers one block of scan-order coefficients, then emits EOB and per-coefficient
// level/sign/Golomb symbols in reverse scan order. All outputs come straight from flops.
module av2_coeff_encoder #(
    parameter int unsigned MAX_COEFFS = 64,
    parameter int unsigned COEFF_W    = 16
) (
    input logic                clk,
    input logic                rst,
    av2_coeff_encoder_if.slave bus
);
    localparam int unsigned AW = (MAX_COEFFS > 1) ? $clog2(MAX_COEFFS) : 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StEmitEob, StEmitLevel, StEmitSign, StEmitGolomb, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  tx_q, tx_d;
    logic [8:0]  n_q, n_d;
    logic [8:0]  k_q, k_d;
    logic [8:0]  eob_q, eob_d;
    logic [7:0]  idx_q, idx_d;
    logic signed [COEFF_W-1:0] mem_q [MAX_COEFFS];

    logic        coeff_ready_q, coeff_ready_d;
    logic        symbol_valid_q, symbol_valid_d;
    logic [15:0] symbol_q, symbol_d;
    logic [15:0] ctx_q, ctx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        coeff_acc, sym_acc, step_c;
    logic signed [COEFF_W-1:0] cur_c, nxt_c;
    logic [15:0] mag_cur, mag_nxt;
    logic [1:0]  kind_d;
    logic [7:0]  pos_d;

    // Magnitude as unsigned, so the most negative code maps to 2^(W-1).
    function automatic logic [15:0] abs16(input logic signed [COEFF_W-1:0] v);
        logic [COEFF_W-1:0] m;
        m = v[COEFF_W-1] ? (~v + COEFF_W'(1)) : v;
        return 16'(m);
    endfunction

    assign coeff_acc = bus.coeff_valid & coeff_ready_q;
    assign sym_acc   = symbol_valid_q & bus.symbol_ready;
    assign cur_c     = mem_q[idx_q[AW-1:0]];
    assign mag_cur   = abs16(cur_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tx_q    <= '0;
            n_q     <= '0;
            k_q     <= '0;
            eob_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            n_q     <= n_d;
            k_q     <= k_d;
            eob_q   <= eob_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StLoad && coeff_acc) mem_q[k_q[AW-1:0]] <= bus.coeff_in;
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        n_d     = n_q;
        k_d     = k_q;
        eob_d   = eob_q;
        idx_d   = idx_q;
        step_c  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    tx_d = bus.tx_size;
                    if (bus.num_coeffs == 16'd0 || {16'd0, bus.num_coeffs} > MAX_COEFFS) begin
                        n_d = 9'(MAX_COEFFS);
                    end else begin
                        n_d = bus.num_coeffs[8:0];
                    end
                    k_d     = '0;
                    eob_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (coeff_acc) begin
                    k_d = k_q + 9'd1;
                    if (bus.coeff_in != '0) eob_d = k_q + 9'd1;
                    if (k_q + 9'd1 == n_q) state_d = StEmitEob;
                end
            end
            StEmitEob: begin
                if (sym_acc) begin
                    if (eob_q == 9'd0) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = 8'(eob_q - 9'd1);
                        state_d = StEmitLevel;
                    end
                end
            end
            StEmitLevel: begin
                if (sym_acc) begin
                    if (mag_cur == 16'd0) step_c = 1'b1;
                    else                  state_d = StEmitSign;
                end
            end
            StEmitSign: begin
                if (sym_acc) begin
                    if (mag_cur >= 16'd15) state_d = StEmitGolomb;
                    else                   step_c = 1'b1;
                end
            end
            StEmitGolomb: begin
                if (sym_acc) step_c = 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (step_c) begin
            if (idx_q == 8'd0) begin
                state_d = StDone;
            end else begin
                idx_d   = idx_q - 8'd1;
                state_d = StEmitLevel;
            end
        end
    end

    // Outputs are computed from the next state so they can be registered without latency.
    assign nxt_c   = mem_q[idx_d[AW-1:0]];
    assign mag_nxt = abs16(nxt_c);

    always_comb begin
        coeff_ready_d  = 1'b0;
        symbol_valid_d = 1'b0;
        symbol_d       = 16'd0;
        kind_d         = 2'b00;
        pos_d          = 8'd0;
        done_d         = 1'b0;
        busy_d         = (state_d != StIdle);
        unique case (state_d)
            StLoad: coeff_ready_d = 1'b1;
            StEmitEob: begin
                symbol_valid_d = 1'b1;
                symbol_d       = {7'd0, eob_d};
            end
            StEmitLevel: begin
                symbol_valid_d = 1'b1;
                symbol_d       = (mag_nxt >= 16'd15) ? 16'd15 : mag_nxt;
                kind_d         = 2'b01;
                pos_d          = idx_d;
            end
            StEmitSign: begin
                symbol_valid_d = 1'b1;
                symbol_d       = {15'd0, nxt_c[COEFF_W-1]};
                kind_d         = 2'b10;
            end
            StEmitGolomb: begin
                symbol_valid_d = 1'b1;
                symbol_d       = mag_nxt - 16'd15;
                kind_d         = 2'b11;
            end
            StDone:  done_d = 1'b1;
            default: ;
        endcase
        ctx_d = symbol_valid_d ? {tx_d, kind_d, pos_d} : 16'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coeff_ready_q  <= 1'b0;
            symbol_valid_q <= 1'b0;
            symbol_q       <= 16'd0;
            ctx_q          <= 16'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            coeff_ready_q  <= coeff_ready_d;
            symbol_valid_q <= symbol_valid_d;
            symbol_q       <= symbol_d;
            ctx_q          <= ctx_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign bus.coeff_ready  = coeff_ready_q;
    assign bus.symbol_valid = symbol_valid_q;
    assign bus.symbol       = symbol_q;
    assign bus.context_idx  = ctx_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_av2_coeff_encoder.sv
// Randomized bench for av2_coeff_encoder: a queue-based reference model of the symbol
// stream is checked against the DUT on every cycle a symbol is presented.
module tb_av2_coeff_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    av2_coeff_encoder_if #(.COEFF_W(16)) bus ();
    av2_coeff_encoder #(.MAX_COEFFS(64), .COEFF_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_pass = 0;
    int ready_pct = 100;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [31:0] exp_q [$];
    logic signed [15:0] cbuf [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: condition not met at %0t", name, $time);
    endtask

    function automatic int eff_n(input int req);
        return (req == 0 || req > 64) ? 64 : req;
    endfunction

    // Reference: expected {symbol, context_idx} words straight from the block contents.
    task automatic build_expected(input int n, input logic [5:0] tx);
        int eob = 0;
        int t = int'(tx) << 10;
        for (int k = 0; k < n; k++) if (cbuf[k] != 0) eob = k + 1;
        exp_q.push_back(32'((eob << 16) | t));
        for (int i = eob - 1; i >= 0; i--) begin
            int v = int'(cbuf[i]);
            int a = (v < 0) ? -v : v;
            exp_q.push_back(32'((((a > 15) ? 15 : a) << 16) | t | (1 << 8) | ((i > 255) ? 255 : i)));
            if (a != 0) exp_q.push_back(32'((((v < 0) ? 1 : 0) << 16) | t | (2 << 8)));
            if (a >= 15) exp_q.push_back(32'(((a - 15) << 16) | t | (3 << 8)));
        end
    endtask

    task automatic fill_random(input int n);
        for (int k = 0; k < n; k++) begin
            int r = $urandom_range(0, 9);
            int v;
            if (r < 5)       v = 0;
            else if (r < 8)  v = $urandom_range(1, 20);
            else if (r == 8) v = $urandom_range(15, 300);
            else             v = ($urandom_range(0, 1) != 0) ? 32768 : 32767;
            if (v != 32768 && $urandom_range(0, 1) != 0) v = -v;
            if (v == 32768) v = -32768;
            cbuf[k] = 16'(v);
        end
    endtask

    task automatic clear_buf();
        for (int k = 0; k < 256; k++) cbuf[k] = 16'sd0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.symbol_valid) begin
                check("no_overlap", 32'(bus.coeff_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    fail_now("extra_symbol");
                end else begin
                    check("symbol", {bus.symbol, bus.context_idx}, exp_q[0]);
                    if (bus.symbol_ready) void'(exp_q.pop_front());
                end
            end
            if (bus.coeff_valid && bus.coeff_ready) acc_cnt++;
            if (bus.done) done_cnt++;
        end
    end

    initial begin
        bus.symbol_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.symbol_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Entered and left at posedge+1.
    task automatic load_coeffs(input int n, input bit extra_start);
        for (int k = 0; k < n; k++) begin
            int g = 0;
            while ($urandom_range(0, 3) == 0) begin
                bus.coeff_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.coeff_valid = 1'b1;
            bus.coeff_in    = cbuf[k];
            if (extra_start && k == n / 2) bus.start = 1'b1;
            do begin
                @(negedge clk);
                g++;
            end while (!bus.coeff_ready && g < 50);
            if (!bus.coeff_ready) begin
                fail_now("coeff_ready_timeout");
                bus.coeff_valid = 1'b0;
                bus.start = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        bus.coeff_valid = 1'b0;
    endtask

    task automatic start_block(input int n_req, input logic [5:0] tx, input int pct);
        acc_cnt = 0;
        ready_pct = pct;
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.tx_size    = tx;
        bus.num_coeffs = 16'(n_req);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("ready_after_start", 32'(bus.coeff_ready), 32'd1);
    endtask

    task automatic run_block(input int n_req, input logic [5:0] tx, input int pct,
                             input bit extra_start);
        int n = eff_n(n_req);
        int g = 0;
        start_block(n_req, tx, pct);
        load_coeffs(n, extra_start);
        @(negedge clk);
        check("ready_drop", 32'(bus.coeff_ready), 32'd0);
        check("eob_valid", 32'(bus.symbol_valid), 32'd1);
        while (!bus.done && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (!bus.done) begin
            fail_now("done_timeout");
            return;
        end
        check("accept_count", 32'(acc_cnt), 32'(n));
        check("all_symbols_seen", 32'(exp_q.size()), 32'd0);
        check("done_valid_low", 32'(bus.symbol_valid), 32'd0);
        check("done_busy_high", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("busy_drop", 32'(bus.busy), 32'd0);
        check("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [31:0] pin2 [7];
        logic [31:0] pin3 [4];
        int dc;
        int g;
        pin2 = '{32'h0004_0000, 32'h0002_0103, 32'h0001_0200, 32'h0000_0102,
                 32'h0000_0101, 32'h0001_0100, 32'h0000_0200};
        pin3 = '{32'h0001_0000, 32'h000F_0100, 32'h0001_0200, 32'h7FF1_0300};
        bus.start = 1'b0;
        bus.tx_size = '0;
        bus.num_coeffs = '0;
        bus.coeff_in = '0;
        bus.coeff_valid = 1'b0;
        #3;
        check("rst_valid", 32'(bus.symbol_valid), 32'd0);
        check("rst_ready", 32'(bus.coeff_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_symbol", 32'(bus.symbol), 32'd0);
        check("rst_ctx", 32'(bus.context_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All-zero block: a lone EOB of 0.
        clear_buf();
        build_expected(16, 6'd1);
        check("pin1_len", 32'(exp_q.size()), 32'd1);
        check("pin1_eob", exp_q[0], 32'h0000_0400);
        run_block(16, 6'd1, 100, 1'b0);

        clear_buf();
        cbuf[0] = 16'sd1;
        cbuf[3] = -16'sd2;
        build_expected(16, 6'd0);
        check("pin2_len", 32'(exp_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) check("pin2_word", exp_q[i], pin2[i]);
        run_block(16, 6'd0, 100, 1'b0);

        clear_buf();
        cbuf[0] = -16'sd32768;
        build_expected(1, 6'd0);
        check("pin3_len", 32'(exp_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("pin3_word", exp_q[i], pin3[i]);
        run_block(1, 6'd0, 100, 1'b0);

        // Same block under heavy backpressure.
        clear_buf();
        cbuf[0] = 16'sd1;
        cbuf[3] = -16'sd2;
        build_expected(16, 6'd0);
        run_block(16, 6'd0, 30, 1'b0);

        // num_coeffs=0 selects the full buffer; a second start mid-load must be ignored.
        clear_buf();
        fill_random(63);
        cbuf[63] = 16'sd20;
        build_expected(64, 6'd5);
        check("pin5_eob", exp_q[0], 32'h0040_1400);
        check("pin5_level", exp_q[1], 32'h000F_153F);
        check("pin5_sign", exp_q[2], 32'h0000_1600);
        check("pin5_golomb", exp_q[3], 32'h0005_1700);
        run_block(0, 6'd5, 70, 1'b1);

        for (int b = 0; b < 6; b++) begin
            int nr = $urandom_range(1, 80);
            logic [5:0] tx = 6'($urandom_range(0, 63));
            clear_buf();
            fill_random(eff_n(nr));
            build_expected(eff_n(nr), tx);
            run_block(nr, tx, $urandom_range(30, 100), 1'b0);
        end

        // Abort during a level symbol; no done may follow.
        clear_buf();
        cbuf[0] = 16'sd1;
        cbuf[3] = -16'sd2;
        build_expected(16, 6'd0);
        dc = done_cnt;
        start_block(16, 6'd0, 50);
        load_coeffs(16, 1'b0);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(bus.symbol_valid && bus.context_idx[9:8] == 2'b01) && g < 200);
        if (!(bus.symbol_valid && bus.context_idx[9:8] == 2'b01)) fail_now("level_timeout");
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.symbol_valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_symbol", 32'(bus.symbol), 32'd0);
        check("arst_ctx", 32'(bus.context_idx), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("no_done_after_abort", 32'(done_cnt), 32'(dc));

        build_expected(16, 6'd0);
        run_block(16, 6'd0, 100, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/av2_coeff_encoder.md
# av2_coeff_encoder

Serializes one transform block of quantized coefficients into the context-tagged symbol stream consumed by the arithmetic encoder, the encode-side counterpart of the coefficient decoder. It accepts coefficients in scan order over a valid/ready stream, buffers them, and tracks the end-of-block position during loading. It then emits an EOB symbol followed by per-coefficient level/sign/Golomb symbols in reverse scan order. It sits between the quantizer output and the entropy-encoder symbol input.

## Interface
- MAX_COEFFS, 64, buffer depth in coefficients (power of two, ≤256)
- COEFF_W, 16, signed coefficient width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a block; sampled only in IDLE
- tx_size  in  6  transform size code, latched at start, carried in context_idx[15:10]
- num_coeffs  in  16  coefficients in block, latched at start
- coeff_in  in  COEFF_W  signed coefficient, scan order
- coeff_valid  in  1  coeff_in valid
- coeff_ready  out  1  encoder accepts coeff_in
- symbol  out  16  symbol value
- context_idx  out  16  {tx_size, kind[1:0], pos[7:0]}
- symbol_valid  out  1  symbol/context_idx valid
- symbol_ready  in  1  downstream accepts symbol
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at block completion

## Operation
- States: IDLE, LOAD, EMIT_EOB, EMIT_LEVEL, EMIT_SIGN, EMIT_GOLOMB, DONE.
- IDLE: on start, latch tx_size and N. N = num_coeffs, except num_coeffs = 0 or > MAX_COEFFS, which gives N = MAX_COEFFS. Clear load index and eob, then go to LOAD. start is ignored in every other state.
- LOAD: coeff_ready = 1. On coeff_valid && coeff_ready, write buffer[k] and increment k. If the coefficient is nonzero, set eob = k+1. After the N-th accept, go to EMIT_EOB.
- EMIT_EOB: symbol = eob (0..N), kind 00, pos 0. On accept: go to DONE if eob = 0; otherwise set i = eob-1 and go to EMIT_LEVEL.
- EMIT_LEVEL: a = |buffer[i]| as 16-bit unsigned, so -32768 gives 32768. symbol = min(a,15), kind 01, pos = min(i,255).
  - On accept with a = 0: step to the next coefficient.
  - On accept with a ≠ 0: go to EMIT_SIGN.
- EMIT_SIGN: symbol = 1 if negative else 0, kind 10, pos 0. On accept: go to EMIT_GOLOMB if a ≥ 15, else step.
- EMIT_GOLOMB: symbol = a − 15 (unsigned 16-bit, max 32753), kind 11, pos 0. On accept: step.
- Step: if i = 0, go to DONE; otherwise decrement i and go to EMIT_LEVEL.
- DONE: done = 1 for exactly one cycle, then IDLE.

## Timing
- Reset values: coeff_ready 0, symbol_valid 0, symbol 0, context_idx 0, busy 0, done 0, state IDLE. Buffer contents are don't-care.
- Reset mid-operation (any state): all outputs take reset values immediately. A partial block is discarded and no done pulse is issued.
- All outputs are registered.
- Start and load:
  - start high in IDLE at cycle T gives busy = 1 and coeff_ready = 1 from T+1.
  - Coefficients are loaded at up to one per cycle.
  - coeff_ready drops in the cycle after the N-th accept.
- Emit:
  - The EOB symbol is valid in the cycle after the N-th accept.
  - symbol_valid stays high from the EOB until the final symbol is accepted.
  - Each new symbol appears in the cycle after the previous one is accepted, giving one symbol per cycle with no bubbles when symbol_ready is held high.
- Handshake: while symbol_valid && !symbol_ready, symbol and context_idx are held stable. symbol_valid never drops before acceptance.
- Completion: done pulses in the cycle after the final accept, with symbol_valid = 0 and busy = 1. busy drops the following cycle.
- start asserted during the done cycle is ignored. It is honored in IDLE the cycle after.
- Coefficient loading and emission never overlap.

## Test plan
- N=16, tx_size=1, all zeros -> exactly one symbol 0 with ctx 0x0400, then a done pulse; coeff_ready high for 16 accepts only.
- N=16, c[0]=1, c[3]=-2, others 0 -> symbols (value/ctx) in order: 4/0x0000, 2/0x0103, 1/0x0200, 0/0x0102, 0/0x0101, 1/0x0100, 0/0x0200 (tx_size=0), then done.
- N=1, c[0]=-32768 -> symbols: 1 (EOB), 15 (level), 1 (sign), 32753 (Golomb) with kinds 00, 01, 10, 11, then done.
- Case 2 with symbol_ready random 30% duty -> identical symbol sequence; outputs stable while stalled; no symbol lost or duplicated.
- num_coeffs=0, start pulsed again during LOAD, and last coefficient = 20 -> 64 coefficients loaded, second start ignored, EOB 64, level at pos 63 = 15, sign 0, Golomb 5.
- rst asserted during EMIT_LEVEL -> outputs zero asynchronously and no done pulse; a following start encodes a new block correctly.
